uart_alu_sequencer: RTL and testbench

- Control FSM between UART receiver/transmitter and combinational ALU inside the top-level calculator.
- Collects three received bytes in fixed order: operand A, operand B, opcode. Holds them stable on the ALU inputs.
- Captures the ALU result and launches one UART transmission of it; rejects invalid opcodes and bytes that arrive while busy.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/uart_alu_sequencer.sv | 159 +++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the UART calculator: sequencer state encoding,
// ALU opcode constants and the opcode legality check.
package alu_pkg;

    localparam int NB_STATE = 3;
    localparam int NB_OP    = 6;

    localparam logic [NB_STATE-1:0] WAIT_A    = 3'd0;
    localparam logic [NB_STATE-1:0] WAIT_B    = 3'd1;
    localparam logic [NB_STATE-1:0] WAIT_OP   = 3'd2;
    localparam logic [NB_STATE-1:0] EXEC      = 3'd3;
    localparam logic [NB_STATE-1:0] SEND      = 3'd4;
    localparam logic [NB_STATE-1:0] WAIT_DONE = 3'd5;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
            default:                        is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_sequencer.sv
// Control FSM between the UART and the combinational ALU: collects A, B, opcode,
// then transmits the result. Optional inter-byte timeout: UART_ALU_SEQ_TIMEOUT_EN.
module uart_alu_sequencer
    import alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_CODE        = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMEOUT     = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_CODE-1:0] o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_op_err,
    output logic               o_overrun
);

    if ((2 ** NB_TIMEOUT) <= TIMEOUT_CYCLES) begin : g_bad_timeout_width
        $error("NB_TIMEOUT too narrow for TIMEOUT_CYCLES");
    end

    logic [NB_STATE-1:0] state_reg, state_next;
    logic [NB_DATA-1:0]  alu_a_reg, alu_a_next;
    logic [NB_DATA-1:0]  alu_b_reg, alu_b_next;
    logic [NB_CODE-1:0]  alu_op_reg, alu_op_next;
    logic [NB_DATA-1:0]  tx_data_reg, tx_data_next;
    logic                tx_start_reg, tx_start_next;
    logic                busy_reg, busy_next;
    logic                op_err_reg, op_err_next;
    logic                overrun_reg, overrun_next;

    logic op_ok;
    logic busy_state;
    logic timeout_hit;

    assign op_ok = (i_rx_data[NB_DATA-1:NB_CODE] == '0) && is_valid_op(i_rx_data[NB_CODE-1:0]);
    assign busy_state = (state_reg == EXEC) || (state_reg == SEND) || (state_reg == WAIT_DONE);

`ifdef UART_ALU_SEQ_TIMEOUT_EN
    logic [NB_TIMEOUT-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic                  in_frame;

    assign in_frame = (state_reg == WAIT_B) || (state_reg == WAIT_OP);

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = in_frame && !i_rx_done_tick &&
                         (timeout_cnt_reg >= NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timeout_cnt_next = '0;
        if (in_frame && !i_rx_done_tick) begin
            if (timeout_cnt_reg == {NB_TIMEOUT{1'b1}})
                timeout_cnt_next = timeout_cnt_reg;
            else
                timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            timeout_cnt_reg <= '0;
        else
            timeout_cnt_reg <= timeout_cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= WAIT_A;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            op_err_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            op_err_reg   <= op_err_next;
            overrun_reg  <= overrun_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_A:    if (i_rx_done_tick) state_next = WAIT_B;
            WAIT_B: begin
                if (i_rx_done_tick)   state_next = WAIT_OP;
                else if (timeout_hit) state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (i_rx_done_tick)   state_next = op_ok ? EXEC : WAIT_A;
                else if (timeout_hit) state_next = WAIT_A;
            end
            EXEC:      state_next = SEND;
            SEND:      state_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done_tick) state_next = WAIT_A;
            default:   state_next = WAIT_A;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge
    always_comb begin
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = (state_reg == EXEC);
        busy_next     = (state_next == EXEC) || (state_next == SEND) || (state_next == WAIT_DONE);
        op_err_next   = timeout_hit;
        overrun_next  = i_rx_done_tick && busy_state;

        if (i_rx_done_tick) begin
            case (state_reg)
                WAIT_A:  alu_a_next = i_rx_data;
                WAIT_B:  alu_b_next = i_rx_data;
                WAIT_OP: begin
                    if (op_ok) alu_op_next = i_rx_data[NB_CODE-1:0];
                    else       op_err_next = 1'b1;
                end
                default: ;
            endcase
        end

        if (state_reg == EXEC)
            tx_data_next = i_alu_result;
    end

    assign o_alu_a    = alu_a_reg;
    assign o_alu_b    = alu_b_reg;
    assign o_alu_op   = alu_op_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_busy     = busy_reg;
    assign o_op_err   = op_err_reg;
    assign o_overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: table of frames plus directed
// sequences for overrun, reset and (when enabled) the inter-byte timeout.
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_tick;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, op_err, overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_DATA(8), .NB_CODE(6), .TIMEOUT_CYCLES(100), .NB_TIMEOUT(20)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_rx_done_tick(rx_tick), .i_rx_data(rx_data),
        .i_tx_done_tick(tx_done), .i_alu_result(alu_result),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy),
        .o_op_err(op_err), .o_overrun(overrun)
    );

    // Reference combinational ALU driven by the sequencer's operand registers
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: alu_f = a + b;
            6'b100010: alu_f = a - b;
            6'b100100: alu_f = a & b;
            6'b100101: alu_f = a | b;
            6'b100110: alu_f = a ^ b;
            6'b100111: alu_f = ~(a | b);
            6'b000011: alu_f = 8'($signed(a) >>> b);
            6'b000010: alu_f = a >> b;
            default:   alu_f = 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic       valid;
        logic [5:0] exp_op;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{8'h03, 8'h08, 8'h20, 1'b1, 6'h20, 8'h0B};
        vecs[1]  = '{8'h08, 8'h03, 8'h22, 1'b1, 6'h22, 8'h05};
        vecs[2]  = '{8'hF0, 8'h0F, 8'h25, 1'b1, 6'h25, 8'hFF};
        vecs[3]  = '{8'h01, 8'h02, 8'h3F, 1'b0, 6'h25, 8'h00};
        vecs[4]  = '{8'h01, 8'h02, 8'h20, 1'b1, 6'h20, 8'h03};
        vecs[5]  = '{8'hC3, 8'h0F, 8'h24, 1'b1, 6'h24, 8'h03};
        vecs[6]  = '{8'hAA, 8'hFF, 8'h26, 1'b1, 6'h26, 8'h55};
        vecs[7]  = '{8'h0F, 8'hF0, 8'h27, 1'b1, 6'h27, 8'h00};
        vecs[8]  = '{8'h80, 8'h02, 8'h03, 1'b1, 6'h03, 8'hE0};
        vecs[9]  = '{8'h80, 8'h02, 8'h02, 1'b1, 6'h02, 8'h20};
        vecs[10] = '{8'h05, 8'h03, 8'hA0, 1'b0, 6'h02, 8'h00};
        vecs[11] = '{8'h05, 8'h03, 8'h21, 1'b0, 6'h02, 8'h00};

        reset   = 1'b1;
        rx_tick = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {alu_a, alu_b, 2'b00, alu_op, tx_data, 4'b0000, tx_start, busy, op_err, overrun}, 32'h0);

        // Table of frames: opcode tick at n, op valid at n+1, tx_start at n+2
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].a, vecs[i].b, vecs[i].op);
            chk($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].a));
            chk($sformatf("v%0d_alu_b", i), 32'(alu_b), 32'(vecs[i].b));
            chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].exp_op));
            chk($sformatf("v%0d_op_err", i), 32'(op_err), 32'(!vecs[i].valid));
            chk($sformatf("v%0d_tx_start_early", i), 32'(tx_start), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].valid));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].valid));
            chk($sformatf("v%0d_op_err_single", i), 32'(op_err), 32'd0);
            if (vecs[i].valid)
                chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_tx));
            @(negedge clk);
            chk($sformatf("v%0d_tx_start_single", i), 32'(tx_start), 32'd0);
            if (vecs[i].valid) begin
                pulse_tx_done();
                chk($sformatf("v%0d_busy_after_done", i), 32'(busy), 32'd0);
            end
            $display("vector %0d a=%02h b=%02h op=%02h tx_data=%02h op_err_expected=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].op, tx_data, !vecs[i].valid);
        end

        // Overrun in WAIT_DONE, then next byte becomes A
        send_frame(8'h03, 8'h08, 8'h20);
        repeat (2) @(negedge clk);
        send_byte(8'h55);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_alu_a_kept", 32'(alu_a), 32'h03);
        chk("ovr_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ovr_single", 32'(overrun), 32'd0);
        pulse_tx_done();
        send_byte(8'h09);
        chk("ovr_next_a", 32'(alu_a), 32'h09);
        send_byte(8'h01);
        send_byte(8'h22);
        @(negedge clk);
        chk("ovr_frame_tx", 32'(tx_data), 32'h08);
        $display("overrun sequence tx_data=%02h", tx_data);

        // rx and tx_done together in WAIT_DONE: back to WAIT_A, overrun, byte dropped
        @(negedge clk);
        rx_data = 8'h77; rx_tick = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0; tx_done = 1'b0;
        chk("both_overrun", 32'(overrun), 32'd1);
        chk("both_busy", 32'(busy), 32'd0);
        chk("both_alu_a", 32'(alu_a), 32'h09);
        // tx_done outside WAIT_DONE is ignored
        pulse_tx_done();
        send_frame(8'h10, 8'h20, 8'h25);
        chk("both_next_a", 32'(alu_a), 32'h10);
        @(negedge clk);
        chk("both_next_start", 32'(tx_start), 32'd1);
        chk("both_next_tx", 32'(tx_data), 32'h30);
        $display("simultaneous tick sequence tx_data=%02h", tx_data);

        // Reset mid-transmission clears everything
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_tx_outputs", {alu_a, alu_b, 2'b00, alu_op, tx_data, 4'b0000, tx_start, busy, op_err, overrun}, 32'h0);

        // Reset mid-frame drops the partial frame
        send_byte(8'h07);
        chk("rst_partial_a", 32'(alu_a), 32'h07);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_frame_outputs", {alu_a, alu_b, 2'b00, alu_op, tx_data, 4'b0000, tx_start, busy, op_err, overrun}, 32'h0);
        send_frame(8'h01, 8'h01, 8'h20);
        @(negedge clk);
        chk("rst_after_tx", 32'(tx_data), 32'h02);
        chk("rst_after_start", 32'(tx_start), 32'd1);
        pulse_tx_done();
        $display("reset sequence tx_data=%02h", tx_data);

`ifdef UART_ALU_SEQ_TIMEOUT_EN
        // 100 idle cycles after A: timeout
        send_byte(8'h04);
        repeat (99) @(negedge clk);
        chk("to_no_err_yet", 32'(op_err), 32'd0);
        @(negedge clk);
        chk("to_err_pulse", 32'(op_err), 32'd1);
        @(negedge clk);
        chk("to_err_single", 32'(op_err), 32'd0);
        send_byte(8'h06);
        chk("to_back_wait_a", 32'(alu_a), 32'h06);
        chk("to_b_kept", 32'(alu_b), 32'h01);
        $display("timeout sequence alu_a=%02h", alu_a);
        // 99 idle cycles then a byte: accepted, no timeout
        repeat (98) @(negedge clk);
        send_byte(8'h02);
        chk("to_edge_no_err", 32'(op_err), 32'd0);
        chk("to_edge_b", 32'(alu_b), 32'h02);
        send_byte(8'h20);
        @(negedge clk);
        chk("to_edge_tx", 32'(tx_data), 32'h08);
        pulse_tx_done();
        $display("timeout edge sequence tx_data=%02h", tx_data);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
